cla_mw_add_ctrl: RTL and testbench

Multi-word add/subtract sequencer built around one `CLA_top` adder instance. It accepts a pair of NUM_WORDS×DATA_WIDTH-bit operands over a valid/ready handshake. It then steps the single DATA_WIDTH-bit CLA through the words from least to most significant, registering the carry between words, and returns the wide result over a second valid/ready handshake. It sits between wide-operand producers (e.g. crypto/bignum units) and the shared 64-bit CLA datapath, trading latency for area.

---
 rtl/cla_mw_add_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_cla_mw_add_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_mw_add_ctrl.sv
// -----------------------------------------------------------------------------
// cla_mw_add_ctrl
//
// Multi-word add/subtract sequencer. A wide operand pair (NUM_WORDS words of
// DATA_WIDTH bits) is accepted over a valid/ready handshake. One CLA_top
// instance then processes one word per cycle, from least to most significant,
// with the inter-word carry held in a register. The wide result is returned
// over a second valid/ready handshake. This trades latency for adder area.
//
// Ports (W = DATA_WIDTH*NUM_WORDS):
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous active-low reset
//   start_valid  in   1  request valid
//   start_ready  out  1  request accepted on start_valid && start_ready
//   a, b         in   W  operands; word 0 is bits [DATA_WIDTH-1:0]
//   cin          in   1  carry-in for add (ignored when sub = 1)
//   sub          in   1  1: compute a - b
//   busy         out  1  operation in progress or result waiting
//   res_valid    out  1  result valid
//   res_ready    in   1  consumer accepts result on res_valid && res_ready
//   res          out  W  sum / difference (modulo 2^W)
//   cout         out  1  carry out of MSB (for subtract: 1 = no borrow)
//   ovf          out  1  two's-complement overflow of the W-bit result
//
// CLA_top (same file): DATA_WIDTH-bit carry-lookahead adder.
//   i_a, i_b  in   DATA_WIDTH  addends
//   i_cin     in   1           carry-in
//   o_sum     out  DATA_WIDTH  sum
//   o_cout    out  1           carry-out
// -----------------------------------------------------------------------------

module CLA_top #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_cin,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_cout
);

  // The adder is built from 4-bit lookahead groups. The operands are
  // zero-padded up to a whole number of groups. Padded bits have g = p = 0,
  // so they never disturb the carry into bit DATA_WIDTH.
  localparam int NG = (DATA_WIDTH + 3) / 4;
  localparam int PW = NG * 4;

  logic [PW-1:0] w_g;
  logic [PW-1:0] w_p;
  logic [PW:0]   w_c;

  assign w_g = PW'(i_a) & PW'(i_b);
  assign w_p = PW'(i_a) ^ PW'(i_b);

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    w_c    = '0;
    w_c[0] = i_cin;
    for (int k = 0; k < NG; k++) begin
      // Every carry inside the group is formed directly from the group
      // carry-in. Carries do not ripple bit to bit.
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
      w_c[4*k+2] = w_g[4*k+1]
                 | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+3] = w_g[4*k+2]
                 | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      // Group generate / propagate feed the next group's carry-in.
      w_c[4*k+4] = w_g[4*k+3]
                 | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (&w_p[4*k +: 4] & w_c[4*k]);
    end
  end

  assign o_sum  = w_p[DATA_WIDTH-1:0] ^ w_c[DATA_WIDTH-1:0];
  assign o_cout = w_c[DATA_WIDTH];

endmodule

module cla_mw_add_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] a,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] b,
  input  logic                            cin,
  input  logic                            sub,
  output logic                            busy,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] res,
  output logic                            cout,
  output logic                            ovf
);

  localparam int W  = DATA_WIDTH * NUM_WORDS;
  localparam int IW = $clog2(NUM_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]          r_op_a;
  logic [W-1:0]          r_op_b;
  logic [DATA_WIDTH-1:0] r_res_word [NUM_WORDS];
  logic [IW-1:0]         r_idx;
  logic                  r_carry;
  logic                  r_sa;
  logic                  r_sb;
  logic                  r_cout;
  logic                  r_ovf;

  logic [DATA_WIDTH-1:0] w_a_word [NUM_WORDS];
  logic [DATA_WIDTH-1:0] w_b_word [NUM_WORDS];
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_cout;
  logic                  w_accept;
  logic                  w_last;

  // Word views of the operand registers, and packing of the result words.
  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_words
    assign w_a_word[g] = r_op_a[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_word[g] = r_op_b[g*DATA_WIDTH +: DATA_WIDTH];
    assign res[g*DATA_WIDTH +: DATA_WIDTH] = r_res_word[g];
  end

  assign w_accept = start_valid && (r_state == ST_IDLE);
  assign w_last   = (r_idx == LAST_IDX);

  CLA_top #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cla (
    .i_a    (w_a_word[r_idx]),
    .i_b    (w_b_word[r_idx]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge value no matter how the blocks are ordered.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    start_ready = 1'b0;
    busy        = 1'b0;
    res_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture. Subtraction is A + ~B + 1, so B is inverted here once.
  // ---------------------------------------------------------------------------
  // NOTE: the wide operand registers are not reset. They are always loaded at
  // accept before they are read, and leaving them unreset keeps the reset net
  // off 2*W flops.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op_a <= a;
      r_op_b <= sub ? ~b : b;
    end
  end

  // ---------------------------------------------------------------------------
  // Word sequencing, carry chain and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) r_res_word[i] <= '0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_carry <= sub | cin;
      r_sa    <= a[W-1];
      r_sb    <= sub ? ~b[W-1] : b[W-1];
    end else if (r_state == ST_RUN) begin
      r_res_word[r_idx] <= w_sum;
      r_carry           <= w_cout;
      if (w_last) begin
        // The top word's carry goes only to cout. Overflow means both
        // operands had the same sign and the result sign differs from it.
        r_idx  <= '0;
        r_cout <= w_cout;
        r_ovf  <= (r_sa == r_sb) && (w_sum[DATA_WIDTH-1] != r_sa);
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_mw_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cla_mw_add_ctrl
//
// Self-checking bench for cla_mw_add_ctrl at the default size (4 x 64 bits).
// Expected results are pushed to a scoreboard queue when a request is
// accepted. They are popped and compared when the result handshake fires.
// Directed vectors come from a table. Latency, backpressure and mid-run reset
// are covered by short hand-written sequences. A random back-to-back phase
// with result stalls closes the test.
// -----------------------------------------------------------------------------

module tb_cla_mw_add_ctrl;

  localparam int DW = 64;
  localparam int NW = 4;
  localparam int W  = DW * NW;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    exp_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  cla_mw_add_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res         (res),
    .cout        (cout),
    .ovf         (ovf)
  );

  exp_t sb_q [$];
  exp_t next_exp;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_acc    = 0;
  int   n_res    = 0;
  bit   last_fs;
  bit   last_fr;

  // Reference: {cout, res} = a + (sub ? ~b : b) + (sub ? 1 : cin), W+1 bits.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    logic [W-1:0] bb;
    logic [W:0]   s;
    exp_t         e;
    bb     = msub ? ~mb : mb;
    s      = {1'b0, ma} + {1'b0, bb} + (W+1)'(msub ? 1'b1 : mcin);
    e.res  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (ma[W-1] == bb[W-1]) && (s[W-1] != ma[W-1]);
    return e;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic vcin, input logic vsub,
                              input logic [W-1:0] eres, input logic ecout,
                              input logic eovf);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vcin; v.sub = vsub;
    v.exp.res = eres; v.exp.cout = ecout; v.exp.ovf = eovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  task automatic rand_wide(output logic [W-1:0] v);
    for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
  endtask

  // One clock cycle, evaluated at posedge+1. The handshakes that will fire at
  // the next edge are evaluated first, from the current stable signals.
  task automatic step();
    exp_t e;
    last_fs = start_valid && start_ready;
    last_fr = res_valid && res_ready;
    if (last_fr) begin
      n_res++;
      if (sb_q.size() == 0) begin
        fail_now("unexpected_result");
      end else begin
        e = sb_q.pop_front();
        check("res",  res,         e.res);
        check("cout", W'(cout),    W'(e.cout));
        check("ovf",  W'(ovf),     W'(e.ovf));
      end
    end
    if (last_fs) begin
      n_acc++;
      sb_q.push_back(next_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub, input exp_t e);
    bit got;
    got = 1'b0;
    a = ia; b = ib; cin = icin; sub = isub; next_exp = e;
    start_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_fs) begin
        got = 1'b1;
        break;
      end
    end
    start_valid = 1'b0;
    if (!got) fail_now("accept_timeout");
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) break;
      step();
    end
    if (sb_q.size() != 0) begin
      fail_now("result_timeout");
      sb_q.delete();
    end
  endtask

  vec_t         vecs [10];
  logic [W-1:0] ones, maxpos, minneg, ra, rb;
  logic         rcin, rsub;
  int           acc_before, res_base, issued;

  initial begin
    ones   = {W{1'b1}};
    maxpos = {1'b0, {(W-1){1'b1}}};
    minneg = {1'b1, {(W-1){1'b0}}};

    vecs[0] = mk(W'(5),  W'(7), 1'b0, 1'b1, ones - W'(1), 1'b0, 1'b0);
    vecs[1] = mk(W'(7),  W'(5), 1'b0, 1'b1, W'(2),        1'b1, 1'b0);
    vecs[2] = mk(maxpos, W'(1), 1'b0, 1'b0, minneg,       1'b0, 1'b1);
    vecs[3] = mk(minneg, minneg, 1'b0, 1'b0, W'(0),       1'b1, 1'b1);
    vecs[4] = mk(W'(0),  W'(0), 1'b1, 1'b0, W'(1),        1'b0, 1'b0);
    vecs[5] = mk(W'(10), W'(3), 1'b1, 1'b1, W'(7),        1'b1, 1'b0);
    vecs[6] = mk(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, 1'b0,
                 W'(1) << 64, 1'b0, 1'b0);
    vecs[7] = mk(W'(0),  W'(0), 1'b0, 1'b1, W'(0),        1'b1, 1'b0);
    vecs[8] = mk(minneg, W'(1), 1'b0, 1'b1, maxpos,       1'b1, 1'b1);
    vecs[9] = mk(ones,   ones,  1'b1, 1'b0, ones,         1'b1, 1'b0);

    rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    sub = 1'b0; res_ready = 1'b0; next_exp = '0;

    // Reset state, sampled while reset is held.
    #12;
    check("rst_res",         res,               '0);
    check("rst_cout",        W'(cout),          '0);
    check("rst_ovf",         W'(ovf),           '0);
    check("rst_res_valid",   W'(res_valid),     '0);
    check("rst_busy",        W'(busy),          '0);
    check("rst_start_ready", W'(start_ready),   W'(1));
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Carry chain through all words, with the exact latency check.
    issue(ones, W'(1), 1'b0, 1'b0, '{res: '0, cout: 1'b1, ovf: 1'b0});
    check("lat_busy", W'(busy), W'(1));
    step(); step(); step();
    check("lat_valid_e3", W'(res_valid), '0);
    step();
    check("lat_valid_e4", W'(res_valid), W'(1));
    res_ready = 1'b1;
    drain(5);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp);
      drain(20);
    end

    // Backpressure: result held, new requests refused.
    res_ready = 1'b0;
    issue(W'(3), W'(4), 1'b0, 1'b0, '{res: W'(7), cout: 1'b0, ovf: 1'b0});
    for (int i = 0; i < 20; i++) begin
      if (res_valid) break;
      step();
    end
    check("bp_valid", W'(res_valid), W'(1));
    acc_before  = n_acc;
    start_valid = 1'b1;
    next_exp    = '{res: ones, cout: 1'b1, ovf: 1'b1};
    for (int i = 0; i < 10; i++) begin
      rand_wide(ra); rand_wide(rb);
      a = ra; b = rb; sub = i[0];
      step();
      check("bp_res",         res,              W'(7));
      check("bp_cout",        W'(cout),         '0);
      check("bp_ovf",         W'(ovf),          '0);
      check("bp_start_ready", W'(start_ready),  '0);
      check("bp_res_valid",   W'(res_valid),    W'(1));
    end
    check("bp_no_accept", W'(n_acc), W'(acc_before));
    start_valid = 1'b0;
    res_ready   = 1'b1;
    step();
    check("bp_valid_drop",  W'(res_valid),   '0);
    check("bp_idle_ready",  W'(start_ready), W'(1));
    check("bp_sb_empty",    W'(sb_q.size()), '0);

    // Reset two cycles after accept aborts the operation.
    issue(W'(5), W'(6), 1'b0, 1'b0, model(W'(5), W'(6), 1'b0, 1'b0));
    step(); step();
    rst_n = 1'b0;
    #1;
    check("mrst_res",         res,             '0);
    check("mrst_cout",        W'(cout),        '0);
    check("mrst_ovf",         W'(ovf),         '0);
    check("mrst_res_valid",   W'(res_valid),   '0);
    check("mrst_busy",        W'(busy),        '0);
    check("mrst_start_ready", W'(start_ready), W'(1));
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(W'(1), W'(1), 1'b0, 1'b0, '{res: W'(2), cout: 1'b0, ovf: 1'b0});
    drain(20);

    // Random back-to-back traffic with result stalls.
    res_base = n_res;
    issued   = 0;
    rand_wide(ra); rand_wide(rb);
    rcin = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
    a = ra; b = rb; cin = rcin; sub = rsub;
    next_exp    = model(ra, rb, rcin, rsub);
    start_valid = 1'b1;
    for (int cyc = 0; cyc < 20000 && (n_res - res_base) < 500; cyc++) begin
      step();
      if (last_fs) begin
        issued++;
        if (issued < 500) begin
          rand_wide(ra); rand_wide(rb);
          rcin = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
          a = ra; b = rb; cin = rcin; sub = rsub;
          next_exp = model(ra, rb, rcin, rsub);
        end else begin
          start_valid = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    check("rand_count", W'(n_res - res_base), W'(500));
    check("rand_sb_empty", W'(sb_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
